// File: rtl/fifo_rd_burst_ctrl.sv
// Read-side burst sequencer for the 8-bit read port of the reshape FIFO.
// It waits for a burst trigger and issues up to BURST_LEN read enables.
// It tracks outstanding beats, drains them, and checks that the returned
// data forms an incrementing byte sequence.
module fifo_rd_burst_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BURST_LEN      = 64,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned RD_LATENCY_MAX = 4,
  parameter int unsigned TIMEOUT        = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  pause_i,
  input  logic                  fifo_rst_busy_i,
  input  logic                  fifo_prog_full_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_rd_valid_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  burst_active_o,
  output logic                  burst_done_o,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o,
  output logic [CNT_WIDTH-1:0]  burst_cnt_o,
  output logic                  data_err_o,
  output logic                  timeout_err_o
);

  localparam int unsigned ISSUE_W = $clog2(BURST_LEN + 1);
  // Sized for a full burst plus the beats still in the read pipeline.
  localparam int unsigned OUTS_W  = $clog2(BURST_LEN + RD_LATENCY_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ISSUE_W-1:0]      issue_cnt;
  logic [OUTS_W-1:0]       outstanding;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [DATA_WIDTH-1:0]   expected;
  logic                    first_seen;
  logic                    done_set;
  logic                    tmo_set;
  logic                    busy_abort;

  // Next-state, read-enable issue, and completion/timeout events
  always_comb begin
    state_nx     = state;
    fifo_rd_en_o = 1'b0;
    done_set     = 1'b0;
    tmo_set      = 1'b0;
    busy_abort   = 1'b0;

    if (state == ST_BURST) begin
      fifo_rd_en_o = !fifo_empty_i && !pause_i &&
                     (issue_cnt < ISSUE_W'(BURST_LEN));
    end

    case (state)
      ST_INIT: begin
        if (!fifo_rst_busy_i) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (enable_i && !fifo_rst_busy_i &&
            (fifo_prog_full_i || (flush_i && !fifo_empty_i))) begin
          state_nx = ST_BURST;
        end
      end
      ST_BURST: begin
        if (fifo_rd_en_o && (issue_cnt == ISSUE_W'(BURST_LEN - 1))) begin
          state_nx = ST_DRAIN;
        end else if (issue_cnt >= ISSUE_W'(BURST_LEN)) begin
          state_nx = ST_DRAIN;
        end else if (fifo_empty_i && !pause_i && (issue_cnt != '0)) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding == '0) begin
          state_nx = ST_WAIT;
          done_set = 1'b1;
        end else if (!fifo_rd_valid_i && (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
          state_nx = ST_WAIT;
          tmo_set  = 1'b1;
        end
      end
      default: state_nx = ST_INIT;
    endcase

    // FIFO going back into reset aborts whatever the controller was doing
    if (fifo_rst_busy_i && (state != ST_INIT)) begin
      state_nx   = ST_INIT;
      done_set   = 1'b0;
      tmo_set    = 1'b0;
      busy_abort = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_INIT;
    else       state <= state_nx;
  end

  // Burst bookkeeping: issue count, outstanding beats, drain timeout, status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_cnt      <= '0;
      outstanding    <= '0;
      tmo_cnt        <= '0;
      burst_active_o <= 1'b0;
      burst_done_o   <= 1'b0;
      burst_cnt_o    <= '0;
      timeout_err_o  <= 1'b0;
    end else begin
      if ((state == ST_WAIT) && (state_nx == ST_BURST)) begin
        issue_cnt <= '0;
      end else if (fifo_rd_en_o) begin
        issue_cnt <= issue_cnt + ISSUE_W'(1);
      end

      if (busy_abort || tmo_set) begin
        outstanding <= '0;
      end else if (fifo_rd_en_o && !fifo_rd_valid_i) begin
        outstanding <= outstanding + OUTS_W'(1);
      end else if (!fifo_rd_en_o && fifo_rd_valid_i && (outstanding != '0)) begin
        outstanding <= outstanding - OUTS_W'(1);
      end

      if (((state != ST_DRAIN) && (state_nx == ST_DRAIN)) || fifo_rd_valid_i) begin
        tmo_cnt <= '0;
      end else if ((state == ST_DRAIN) && (tmo_cnt != TMO_W'(TIMEOUT))) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      burst_active_o <= (state_nx == ST_BURST) || (state_nx == ST_DRAIN);
      burst_done_o   <= done_set;
      if (done_set) burst_cnt_o <= burst_cnt_o + CNT_WIDTH'(1);
      if (tmo_set)  timeout_err_o <= 1'b1;
    end
  end

  // Data capture, beat counting and incrementing-pattern check
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      beat_cnt_o   <= '0;
      expected     <= '0;
      first_seen   <= 1'b0;
      data_err_o   <= 1'b0;
    end else begin
      data_o       <= fifo_rdata_i;
      data_valid_o <= fifo_rd_valid_i;
      if (fifo_rd_valid_i) begin
        beat_cnt_o <= beat_cnt_o + CNT_WIDTH'(1);
        expected   <= fifo_rdata_i + DATA_WIDTH'(1);
        first_seen <= 1'b1;
        if (first_seen && (fifo_rdata_i != expected)) data_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Directed bench for fifo_rd_burst_ctrl with a behavioural FIFO read-port model.
module tb_fifo_rd_burst_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned LAT = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          flush_i;
  logic          pause_i;
  logic          fifo_rst_busy_i;
  logic          fifo_prog_full_i;
  logic          fifo_empty_i;
  logic          fifo_rd_valid_i;
  logic [DW-1:0] fifo_rdata_i;
  logic          fifo_rd_en_o;
  logic [DW-1:0] data_o;
  logic          data_valid_o;
  logic          burst_active_o;
  logic          burst_done_o;
  logic [CW-1:0] beat_cnt_o;
  logic [CW-1:0] burst_cnt_o;
  logic          data_err_o;
  logic          timeout_err_o;

  always #5 clk_i = ~clk_i;

  fifo_rd_burst_ctrl #(
    .DATA_WIDTH(8), .BURST_LEN(64), .CNT_WIDTH(16), .RD_LATENCY_MAX(4), .TIMEOUT(15)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .pause_i(pause_i), .fifo_rst_busy_i(fifo_rst_busy_i),
    .fifo_prog_full_i(fifo_prog_full_i), .fifo_empty_i(fifo_empty_i),
    .fifo_rd_valid_i(fifo_rd_valid_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_rd_en_o(fifo_rd_en_o), .data_o(data_o), .data_valid_o(data_valid_o),
    .burst_active_o(burst_active_o), .burst_done_o(burst_done_o),
    .beat_cnt_o(beat_cnt_o), .burst_cnt_o(burst_cnt_o),
    .data_err_o(data_err_o), .timeout_err_o(timeout_err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO model: byte count, data generator, fixed-latency valid pipeline
  int            fcount;
  logic [DW-1:0] next_byte;
  logic          pv [LAT];
  logic [DW-1:0] pd [LAT];
  int            drop_after;
  int            burst_en;
  int            done_cnt;
  int            cyc;
  int            last_v_cyc;
  logic          man_mode;
  logic          man_v;
  logic [DW-1:0] man_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive FIFO-side inputs, sample rd_en, advance the model
  task automatic cycle();
    logic en;
    fifo_empty_i = (fcount == 0);
    if (man_mode) begin
      fifo_rd_valid_i = man_v;
      fifo_rdata_i    = man_d;
    end else begin
      fifo_rd_valid_i = pv[LAT-1];
      fifo_rdata_i    = pd[LAT-1];
    end
    #1;
    en = fifo_rd_en_o;
    if (fifo_rd_valid_i) last_v_cyc = cyc + 1;
    @(posedge clk_i);
    #1;
    cyc++;
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
    end
    pv[0] = 1'b0;
    pd[0] = '0;
    if (en) begin
      burst_en++;
      fcount--;
      pv[0] = (drop_after < 0) || (burst_en <= drop_after);
      pd[0] = next_byte;
      next_byte = next_byte + 8'd1;
    end
    if (burst_done_o) done_cnt++;
  endtask

  task automatic wait_done(input string tag);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while ((done_cnt == start) && (k < 400)) begin
      cycle();
      k++;
    end
    check_eq(tag, 32'(done_cnt != start), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_en"}, 32'(fifo_rd_en_o), 32'd0);
    check_eq({tag, "_data"}, 32'(data_o), 32'd0);
    check_eq({tag, "_dvalid"}, 32'(data_valid_o), 32'd0);
    check_eq({tag, "_active"}, 32'(burst_active_o), 32'd0);
    check_eq({tag, "_done"}, 32'(burst_done_o), 32'd0);
    check_eq({tag, "_beats"}, 32'(beat_cnt_o), 32'd0);
    check_eq({tag, "_bursts"}, 32'(burst_cnt_o), 32'd0);
    check_eq({tag, "_derr"}, 32'(data_err_o), 32'd0);
    check_eq({tag, "_terr"}, 32'(timeout_err_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] wrap_seq [5];
    int start_done;
    int paused_en;
    int paused_idle;
    int pre;
    int k;

    rst_i = 1'b1; enable_i = 1'b0; flush_i = 1'b0; pause_i = 1'b0;
    fifo_rst_busy_i = 1'b1; fifo_prog_full_i = 1'b0;
    fifo_empty_i = 1'b1; fifo_rd_valid_i = 1'b0; fifo_rdata_i = '0;
    fcount = 0; next_byte = '0; drop_after = -1; burst_en = 0;
    done_cnt = 0; cyc = 0; last_v_cyc = 0;
    man_mode = 1'b0; man_v = 1'b0; man_d = '0;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end

    cycle(); cycle();
    check_all_zero("rst");
    rst_i = 1'b0;

    // Reset sequencing: no reads while busy, burst two cycles after busy falls
    fcount = 200; fifo_prog_full_i = 1'b1; enable_i = 1'b1;
    repeat (10) cycle();
    check_eq("busy_no_rden", 32'(burst_en), 32'd0);
    fifo_rst_busy_i = 1'b0;
    cycle();
    check_eq("busy_fall_c1_idle", 32'(burst_active_o), 32'd0);
    cycle();
    check_eq("busy_fall_c2_burst", 32'(burst_active_o), 32'd1);
    fifo_prog_full_i = 1'b0;
    wait_done("t1_done_seen");
    repeat (5) cycle();
    check_eq("t1_rd_en_total", 32'(burst_en), 32'd64);
    check_eq("t1_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("t1_burst_cnt", 32'(burst_cnt_o), 32'd1);
    check_eq("t1_beat_cnt", 32'(beat_cnt_o), 32'd64);
    check_eq("t1_data_err", 32'(data_err_o), 32'd0);

    // Short flush burst of 20 bytes
    fcount = 20; burst_en = 0; flush_i = 1'b1;
    wait_done("t2_done_seen");
    check_eq("t2_beats_at_done", 32'(beat_cnt_o), 32'd84);
    flush_i = 1'b0;
    repeat (5) cycle();
    check_eq("t2_rd_en_total", 32'(burst_en), 32'd20);
    check_eq("t2_burst_cnt", 32'(burst_cnt_o), 32'd2);
    check_eq("t2_beats_settled", 32'(beat_cnt_o), 32'd84);

    // Pause for burst cycles 10..19
    fcount = 200; burst_en = 0; fifo_prog_full_i = 1'b1;
    k = 0;
    while (!burst_active_o && (k < 10)) begin cycle(); k++; end
    check_eq("t3_started", 32'(burst_active_o), 32'd1);
    fifo_prog_full_i = 1'b0;
    start_done = done_cnt; paused_en = 0; paused_idle = 0; k = 0;
    while ((done_cnt == start_done) && (k < 400)) begin
      pause_i = (k >= 10) && (k < 20);
      pre = burst_en;
      cycle();
      if (pause_i && (burst_en != pre)) paused_en++;
      if (pause_i && !burst_active_o) paused_idle++;
      k++;
    end
    pause_i = 1'b0;
    check_eq("t3_done_seen", 32'(done_cnt != start_done), 32'd1);
    check_eq("t3_rd_en_in_pause", 32'(paused_en), 32'd0);
    check_eq("t3_left_burst_in_pause", 32'(paused_idle), 32'd0);
    check_eq("t3_rd_en_total", 32'(burst_en), 32'd64);
    repeat (5) cycle();
    check_eq("t3_burst_cnt", 32'(burst_cnt_o), 32'd3);
    check_eq("t3_beat_cnt", 32'(beat_cnt_o), 32'd148);

    // Pattern wrap and sticky mismatch; enable low blocks new bursts
    enable_i = 1'b0;
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    check_all_zero("rst2");
    burst_en = 0; fifo_prog_full_i = 1'b1; fcount = 200;
    repeat (5) cycle();
    check_eq("en_low_no_burst", 32'(burst_active_o), 32'd0);
    check_eq("en_low_no_rd_en", 32'(burst_en), 32'd0);
    wrap_seq[0] = 8'hFD; wrap_seq[1] = 8'hFE; wrap_seq[2] = 8'hFF;
    wrap_seq[3] = 8'h00; wrap_seq[4] = 8'h01;
    man_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      man_v = 1'b1; man_d = wrap_seq[i];
      cycle();
      check_eq("wrap_data_o", 32'(data_o), 32'(wrap_seq[i]));
    end
    man_v = 1'b0; cycle();
    check_eq("wrap_no_err", 32'(data_err_o), 32'd0);
    check_eq("wrap_beats", 32'(beat_cnt_o), 32'd5);
    man_v = 1'b1; man_d = 8'h05; cycle();
    man_v = 1'b0; cycle();
    check_eq("inject_err", 32'(data_err_o), 32'd1);
    man_v = 1'b1; man_d = 8'h06; cycle();
    man_v = 1'b0; cycle();
    check_eq("err_sticky", 32'(data_err_o), 32'd1);
    check_eq("inject_beats", 32'(beat_cnt_o), 32'd7);
    man_mode = 1'b0;

    // Drain timeout: last three beats of a 64-beat burst never return
    next_byte = 8'h07; fcount = 200; drop_after = 61; burst_en = 0;
    start_done = done_cnt; enable_i = 1'b1;
    k = 0;
    while (!timeout_err_o && (k < 400)) begin
      cycle();
      if (burst_active_o) fifo_prog_full_i = 1'b0;
      k++;
    end
    check_eq("tmo_err_set", 32'(timeout_err_o), 32'd1);
    check_eq("tmo_latency", 32'(cyc - last_v_cyc), 32'd15);
    check_eq("tmo_back_to_wait", 32'(burst_active_o), 32'd0);
    check_eq("tmo_no_done", 32'(done_cnt - start_done), 32'd0);
    check_eq("tmo_burst_cnt", 32'(burst_cnt_o), 32'd0);
    check_eq("tmo_beats", 32'(beat_cnt_o), 32'd68);
    check_eq("tmo_rd_en_total", 32'(burst_en), 32'd64);
    drop_after = -1;
    repeat (3) cycle();

    // Mid-burst reset at the 30th enable
    fcount = 200; burst_en = 0; fifo_prog_full_i = 1'b1;
    k = 0;
    while ((burst_en < 30) && (k < 200)) begin cycle(); k++; end
    check_eq("mid_reached_30", 32'(burst_en), 32'd30);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    check_all_zero("mid_rst");
    burst_en = 0;
    cycle();
    check_eq("mid_c1_idle", 32'(burst_active_o), 32'd0);
    cycle();
    check_eq("mid_c2_burst", 32'(burst_active_o), 32'd1);
    fifo_prog_full_i = 1'b0;
    cycle(); cycle();
    check_eq("mid_inflight_beats", 32'(beat_cnt_o), 32'd4);
    wait_done("mid_done_seen");
    repeat (10) cycle();
    check_eq("mid_rd_en_total", 32'(burst_en), 32'd64);
    check_eq("mid_beats", 32'(beat_cnt_o), 32'd68);
    check_eq("mid_burst_cnt", 32'(burst_cnt_o), 32'd1);
    check_eq("mid_data_err", 32'(data_err_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
